// File: rtl/ssd_pkg.sv
// Shared types and active-low segment patterns (bit order g..a) for the
// seven-segment display bank.
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment lookup covering 0-F.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_bank.sv
// Registered multi-digit seven-segment driver: captured hex word, leading-zero
// blanking, per-digit blink and PWM dimming, all outputs active-low.
module ssd_bank
  import ssd_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000,
  parameter int DIM_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [7*DIGITS-1:0]   hex_n,
  output logic [DIGITS-1:0]     dp_n
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] value_q;
  logic                blz_q;
  logic [DIGITS-1:0]   blink_q;
  logic [DIGITS-1:0]   dp_q;
  logic                valid;
  logic [CNT_W-1:0]    blink_cnt;
  logic                phase;
  logic [DIM_BITS-1:0] pwm_cnt;

  logic [7*DIGITS-1:0] hex_next;
  logic [DIGITS-1:0]   dp_next;
  logic                pwm_on;
  seg_t                seg_dec [DIGITS];

  // zero_above[i]: every nibble from digit i up to the top digit is zero
  logic [DIGITS:1]     zero_above;

  assign pwm_on = (&brightness) || (pwm_cnt < brightness);
  assign zero_above[DIGITS] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic lz_off;
    logic dark;

    ssd_hex_decode u_dec (
      .nibble (value_q[4*gi +: 4]),
      .seg    (seg_dec[gi])
    );

    if (gi == 0) begin : g_lsd
      assign lz_off = 1'b0;
    end else begin : g_upper
      assign zero_above[gi] = zero_above[gi+1] && (value_q[4*gi +: 4] == 4'h0);
      assign lz_off = blz_q && zero_above[gi];
    end

    // Invalid, PWM-off and blink all kill the whole digit including its dp
    assign dark = !valid || !pwm_on || (phase && blink_q[gi]);

    assign hex_next[7*gi +: 7] = (dark || lz_off) ? SEG_BLANK : seg_dec[gi];
    assign dp_next[gi]         = dark ? 1'b1 : ~dp_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      blz_q     <= 1'b0;
      blink_q   <= '0;
      dp_q      <= '0;
      valid     <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      pwm_cnt   <= '0;
      hex_n     <= '1;
      dp_n      <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        blz_q   <= blank_lz;
        blink_q <= blink_en;
        dp_q    <= dp;
        valid   <= 1'b1;
      end

      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      pwm_cnt <= pwm_cnt + 1'b1;
      hex_n   <= hex_next;
      dp_n    <= dp_next;
    end
  end

endmodule

// File: tb/tb_ssd_bank.sv
// Directed bench for ssd_bank: decode, leading-zero blanking, blink, dimming
// and reset behaviour with DIGITS=6, BLINK_DIV=4, DIM_BITS=4.
module tb_ssd_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] value;
  logic        load;
  logic        blank_lz;
  logic [5:0]  blink_en;
  logic [5:0]  dp;
  logic [3:0]  brightness;
  logic [41:0] hex_n;
  logic [5:0]  dp_n;

  int checks   = 0;
  int failures = 0;
  int edge_cnt;
  int lit_cnt;

  localparam logic [41:0] ALL_OFF = '1;

  ssd_bank #(
    .DIGITS    (6),
    .BLINK_DIV (4),
    .DIM_BITS  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .dp         (dp),
    .brightness (brightness),
    .hex_n      (hex_n),
    .dp_n       (dp_n)
  );

  always #5 clk = ~clk;

  // Posedges since reset release, used as the bench's own time base
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] pk(input logic [6:0] s5, s4, s3, s2, s1, s0);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  // Called at a negedge; returns at the following negedge (capture edge passed)
  task automatic do_load(input logic [23:0] v, input logic blz,
                         input logic [5:0] bl, input logic [5:0] d);
    value    = v;
    blank_lz = blz;
    blink_en = bl;
    dp       = d;
    load     = 1'b1;
    $display("LOAD value=%h blank_lz=%0b blink_en=%b dp=%b", v, blz, bl, d);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic        blank;
    logic [6:0]  d0;
    logic        lit;

    rst_n = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0;
    blink_en = '0; dp = '0; brightness = 4'hF;

    // Reset, no load
    repeat (2) @(negedge clk);
    check("rst_hex", hex_n, ALL_OFF);
    check("rst_dp", dp_n, 6'h3F);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("noload_hex", hex_n, ALL_OFF);
    check("noload_dp", dp_n, 6'h3F);

    // Full hex set, including the 2-edge latency
    do_load(24'hFEDCBA, 1'b0, 6'b0, 6'b0);
    check("lat_hex", hex_n, ALL_OFF);
    @(negedge clk);
    check("hex_fedcba", hex_n, pk(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08));
    check("dp_off", dp_n, 6'h3F);
    do_load(24'h987654, 1'b0, 6'b0, 6'b0);
    @(negedge clk);
    check("hex_987654", hex_n, pk(7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19));

    // Back-to-back loads: the last one wins
    do_load(24'h111111, 1'b0, 6'b0, 6'b0);
    do_load(24'h012345, 1'b0, 6'b0, 6'b101010);
    @(negedge clk);
    check("b2b_hex", hex_n, pk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12));
    check("b2b_dp", dp_n, 6'b010101);

    // Leading-zero blanking
    do_load(24'h00A05F, 1'b1, 6'b0, 6'b0);
    @(negedge clk);
    check("lz_a05f", hex_n, pk(7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h0E));
    do_load(24'h000000, 1'b1, 6'b0, 6'b100001);
    @(negedge clk);
    check("lz_zero", hex_n, pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
    check("lz_zero_dp", dp_n, 6'b011110);
    do_load(24'h000000, 1'b0, 6'b0, 6'b0);
    @(negedge clk);
    check("nolz_zero", hex_n, pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));

    // Blink on digit 0 with a mid-phase reload that must not move the boundary
    do_load(24'h000001, 1'b0, 6'b000001, 6'b000001);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 11) load = 1'b0;
      blank = (((edge_cnt - 1) / 4) % 2) == 1;
      d0 = (i >= 12) ? 7'h24 : 7'h79;
      check($sformatf("blink_hex%0d", i), hex_n,
            pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, blank ? 7'h7F : d0));
      check($sformatf("blink_dp%0d", i), dp_n, {5'b11111, blank});
      if (i == 10) begin
        value = 24'h000002;
        load  = 1'b1;
        $display("LOAD value=%h mid-phase", value);
      end
    end

    // Dimming
    do_load(24'hFEDCBA, 1'b0, 6'b0, 6'b0);
    @(negedge clk);
    brightness = 4'h4;
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      lit = ((edge_cnt - 1) % 16) < 4;
      if (hex_n != ALL_OFF) lit_cnt++;
      check($sformatf("dim4_%0d", i), hex_n,
            lit ? pk(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08) : ALL_OFF);
    end
    check("dim4_count", 64'(lit_cnt), 64'd8);
    brightness = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("dim0_%0d", i), hex_n, ALL_OFF);
    end
    brightness = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("dimF_%0d", i), hex_n, pk(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08));
    end

    // Reset mid-operation
    rst_n = 1'b0;
    #1;
    check("midrst_hex", hex_n, ALL_OFF);
    check("midrst_dp", dp_n, 6'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_hex", hex_n, ALL_OFF);
    do_load(24'h987654, 1'b0, 6'b0, 6'b000010);
    check("postrst_lat", hex_n, ALL_OFF);
    @(negedge clk);
    check("postrst_show", hex_n, pk(7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19));
    check("postrst_dp", dp_n, 6'b111101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_bank.md
# ssd_bank

Parametrised multi-digit seven-segment driver for the DE10-Lite HEX0–HEX5 bank. It replaces per-digit combinational decoders with one registered block that:
- captures a packed hex word on a load strobe;
- decodes the full 0–F character set per digit;
- optionally blanks leading zeros;
- blinks selected digits from a free-running prescaler;
- dims the whole bank with a PWM duty setting.

All outputs are active-low and drive the display pins directly.

## Interface
- DIGITS, 6: number of digits driven (1–8).
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (≥2).
- DIM_BITS, 4: width of the brightness control and PWM counter.
- clk  in  1  system clock (50 MHz on the board).
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- value  in  4*DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is least significant (HEX0).
- load  in  1  single-cycle strobe; captures value, blank_lz, blink_en, dp.
- blank_lz  in  1  leading-zero blanking enable.
- blink_en  in  DIGITS  per-digit blink enable.
- dp  in  DIGITS  per-digit decimal point; 1 = lit.
- brightness  in  DIM_BITS  live duty setting; not captured.
- hex_n  out  7*DIGITS  segments of digit i at [7i+6:7i], bit order g..a; 0 = lit.
- dp_n  out  DIGITS  decimal points; 0 = lit.

## Operation
- **Capture.** On a clk edge with load=1, the following registers take their inputs: value_q, blz_q, blink_q, dp_q. On the same edge, valid is set to 1.
- **Before first load.** While valid=0, all outputs are blank (hex_n all ones, dp_n all ones).
- **Decode (active-low, gfedcba).** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Blank = 7F.
- **Leading-zero blanking.** When blz_q=1:
  - Scan from digit DIGITS-1 down.
  - Blank each digit whose nibble is 0 until the first nonzero nibble is reached.
  - Digit 0 is never blanked by this rule.
  - Zeros below the first nonzero digit are shown.
  - A digit's dp is still lit if dp_q is set for it.
- **Blink.**
  - A counter runs 0..BLINK_DIV-1; phase toggles when the counter wraps.
  - While phase=1, every digit with blink_q[i]=1 is fully blank, including its dp.
  - Load does not reset the counter or the phase.
- **Dimming.**
  - pwm_cnt runs free with DIM_BITS width and wraps.
  - Segments are enabled when brightness is all ones, or when pwm_cnt < brightness.
  - brightness = 0 keeps the bank dark.
  - When not enabled, all outputs are 1.
- **Blanking precedence.** reset / valid=0, then PWM off, then blink, then leading-zero, then decode.

## Timing
- **Reset state.** All registers clear: value_q=0, valid=0, phase=0, blink counter=0, pwm_cnt=0. Outputs are all ones, asynchronously, while rst_n=0.
- **Outputs are registered.** Load on edge N updates the capture registers. hex_n/dp_n reflect the new data after edge N+1, giving 2-edge latency from the strobe.
- **Back-to-back loads.** Loads on consecutive cycles are accepted; the last one wins. There is no busy/ready signal.
- **Timing of live and free-running controls.**
  - A brightness change affects the output register on the next edge.
  - A phase toggle at the counter wrap on edge M is visible after edge M+1.
- **Simultaneous events.** Load coinciding with a blink wrap or PWM wrap: both take effect independently on the same edge.
- **Reset mid-operation.** Outputs blank immediately and valid clears. Displays stay blank until the next load.

## Structure
- Package ssd_pkg holds:
  - the 16 segment constants (SEG_0..SEG_F);
  - SEG_BLANK = 7'h7F;
  - a seg_t 7-bit typedef.
- Sub-module ssd_hex_decode: combinational 4-bit to 7-bit active-low lookup, instantiated DIGITS times with a generate loop.
- Kept in ssd_bank itself: capture registers, leading-zero scan, blink prescaler, PWM counter, output register.

## Test plan
All scenarios use DIGITS=6, BLINK_DIV=4, DIM_BITS=4, brightness=F unless stated.
- **Reset, no load.** Assert reset, release it, run 20 cycles with no load → hex_n = all ones, dp_n = 3F.
- **Full hex set.** Load value=24'hFEDCBA, dp=0 → after 2 edges, hex_n digits 5..0 = 0E,06,21,46,03,08. Load 24'h987654 → 10,00,78,02,12,19.
- **Leading-zero blanking.**
  - Load 24'h00A05F with blank_lz=1 → digits 5,4 = 7F; digits 3..0 = 08,40,12,0E.
  - Load 24'h000000 with blank_lz=1 → only digit 0 shows 40.
- **Blink.**
  - Load with blink_en=6'b000001 and dp=6'b000001 → digit 0 alternates: shown for 4 cycles, then fully blank (7F, dp_n[0]=1) for 4 cycles. Other digits are steady.
  - Repeat with a load mid-phase → the phase boundary does not move.
- **Dimming.**
  - brightness=4 → each digit is lit in exactly 4 of every 16 cycles.
  - brightness=0 → always dark.
  - brightness=F → always lit.
- **Reset mid-operation.** Pulse rst_n low for 1 cycle while displaying → outputs go all ones immediately and stay blank until the next load. After that load, data appears 2 edges later.
